// File: rtl/time_counter.sv
// time_counter: BCD HH:MM:SS time-of-day register advanced by rising edges
// of the divided seconds clock, with run/pause and validated time load.
// Optional alarm compare is enabled by defining TIME_COUNTER_ALARM_EN.
module time_counter #(
    parameter int unsigned TICKS_PER_SEC = 1,
    parameter int unsigned HOUR_MODULO   = 24
) (
    input  logic       i_CLK,
    input  logic       i_RST,
    input  logic       i_SEC_CLK,
    input  logic       i_RUN,
    input  logic       i_LOAD,
    input  logic [7:0] i_SET_H,
    input  logic [7:0] i_SET_M,
    input  logic [7:0] i_SET_S,
`ifdef TIME_COUNTER_ALARM_EN
    input  logic       i_ALM_SET,
    input  logic [7:0] i_ALM_H,
    input  logic [7:0] i_ALM_M,
    input  logic       i_ALM_ON,
    output logic       o_ALARM,
`endif
    output logic [7:0] o_H,
    output logic [7:0] o_M,
    output logic [7:0] o_S,
    output logic       o_SEC_PULSE,
    output logic       o_DAY_PULSE,
    output logic       o_LOAD_ERR
);

    localparam int unsigned PW   = 10;
    localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_SEC - 1);
    localparam logic [7:0]    HMOD = 8'(HOUR_MODULO);
    localparam logic [7:0]    HMAX = 8'(HOUR_MODULO - 1);

    // Binary value of a two-digit BCD byte (no digit check; max 165 fits)
    function automatic logic [7:0] bcd_val(input logic [7:0] b);
        return ({4'd0, b[7:4]} * 8'd10) + {4'd0, b[3:0]};
    endfunction

    // Hours valid: both digits decimal and value below the wrap modulus
    function automatic logic hour_ok(input logic [7:0] h);
        return (h[7:4] <= 4'd9) && (h[3:0] <= 4'd9) && (bcd_val(h) < HMOD);
    endfunction

    // Minutes/seconds valid: tens 0..5, units 0..9
    function automatic logic sexa_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

    logic [7:0]    h_q, h_d, m_q, m_d, s_q, s_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          edge_q, edge_d;
    logic          sec_pulse_q, sec_pulse_d;
    logic          day_pulse_q, day_pulse_d;
    logic          load_err_q, load_err_d;

    logic       rise_c, tick_c, load_ok_c;
    logic [7:0] h_inc, m_inc, s_inc;
    logic       c_s, c_m, wrap_c;

`ifdef TIME_COUNTER_ALARM_EN
    logic [7:0] alm_h_q, alm_h_d, alm_m_q, alm_m_d;
    logic       alarm_q, alarm_d;
    logic       alm_ok_c;
`endif

    assign rise_c    = i_SEC_CLK & ~edge_q;
    assign tick_c    = rise_c & i_RUN & (presc_q == PMAX);
    assign load_ok_c = hour_ok(i_SET_H) & sexa_ok(i_SET_M) & sexa_ok(i_SET_S);
`ifdef TIME_COUNTER_ALARM_EN
    assign alm_ok_c  = hour_ok(i_ALM_H) & sexa_ok(i_ALM_M);
`endif

    // One-second increment of the current time with BCD carries
    always_comb begin
        s_inc = s_q;
        m_inc = m_q;
        h_inc = h_q;
        c_s   = 1'b0;
        c_m   = 1'b0;
        wrap_c = 1'b0;
        if (s_q[3:0] == 4'd9) begin
            s_inc[3:0] = 4'd0;
            if (s_q[7:4] == 4'd5) begin
                s_inc[7:4] = 4'd0;
                c_s = 1'b1;
            end else begin
                s_inc[7:4] = s_q[7:4] + 4'd1;
            end
        end else begin
            s_inc[3:0] = s_q[3:0] + 4'd1;
        end
        if (c_s) begin
            if (m_q[3:0] == 4'd9) begin
                m_inc[3:0] = 4'd0;
                if (m_q[7:4] == 4'd5) begin
                    m_inc[7:4] = 4'd0;
                    c_m = 1'b1;
                end else begin
                    m_inc[7:4] = m_q[7:4] + 4'd1;
                end
            end else begin
                m_inc[3:0] = m_q[3:0] + 4'd1;
            end
        end
        if (c_m) begin
            if (bcd_val(h_q) == HMAX) begin
                h_inc  = 8'h00;
                wrap_c = 1'b1;
            end else if (h_q[3:0] == 4'd9) begin
                h_inc = {h_q[7:4] + 4'd1, 4'd0};
            end else begin
                h_inc = {h_q[7:4], h_q[3:0] + 4'd1};
            end
        end
    end

    // Next-state: edge sampling, prescaler, load priority over advance
    always_comb begin
        h_d         = h_q;
        m_d         = m_q;
        s_d         = s_q;
        presc_d     = presc_q;
        edge_d      = i_SEC_CLK;
        sec_pulse_d = 1'b0;
        day_pulse_d = 1'b0;
        load_err_d  = 1'b0;
`ifdef TIME_COUNTER_ALARM_EN
        alm_h_d     = alm_h_q;
        alm_m_d     = alm_m_q;
        alarm_d     = 1'b0;
`endif
        if (rise_c && i_RUN) begin
            presc_d = (presc_q == PMAX) ? '0 : presc_q + PW'(1);
        end
        if (i_LOAD && load_ok_c) begin
            h_d     = i_SET_H;
            m_d     = i_SET_M;
            s_d     = i_SET_S;
            presc_d = '0;
        end else begin
            if (i_LOAD) begin
                load_err_d = 1'b1;
            end
            if (tick_c) begin
                h_d         = h_inc;
                m_d         = m_inc;
                s_d         = s_inc;
                sec_pulse_d = 1'b1;
                day_pulse_d = wrap_c;
`ifdef TIME_COUNTER_ALARM_EN
                alarm_d = i_ALM_ON && (s_inc == 8'h00) &&
                          (m_inc == alm_m_q) && (h_inc == alm_h_q);
`endif
            end
        end
`ifdef TIME_COUNTER_ALARM_EN
        if (i_ALM_SET) begin
            if (alm_ok_c) begin
                alm_h_d = i_ALM_H;
                alm_m_d = i_ALM_M;
            end else begin
                load_err_d = 1'b1;
            end
        end
`endif
    end

    // State registers; edge register resets high to mask a high level at release
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            h_q         <= 8'h00;
            m_q         <= 8'h00;
            s_q         <= 8'h00;
            presc_q     <= '0;
            edge_q      <= 1'b1;
            sec_pulse_q <= 1'b0;
            day_pulse_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            h_q         <= h_d;
            m_q         <= m_d;
            s_q         <= s_d;
            presc_q     <= presc_d;
            edge_q      <= edge_d;
            sec_pulse_q <= sec_pulse_d;
            day_pulse_q <= day_pulse_d;
            load_err_q  <= load_err_d;
        end
    end

`ifdef TIME_COUNTER_ALARM_EN
    // Alarm setting and alarm pulse registers
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            alm_h_q <= 8'h00;
            alm_m_q <= 8'h00;
            alarm_q <= 1'b0;
        end else begin
            alm_h_q <= alm_h_d;
            alm_m_q <= alm_m_d;
            alarm_q <= alarm_d;
        end
    end

    assign o_ALARM = alarm_q;
`endif

    assign o_H         = h_q;
    assign o_M         = m_q;
    assign o_S         = s_q;
    assign o_SEC_PULSE = sec_pulse_q;
    assign o_DAY_PULSE = day_pulse_q;
    assign o_LOAD_ERR  = load_err_q;

endmodule

// File: tb/tb_time_counter.sv
// Testbench for time_counter (TICKS_PER_SEC=1, HOUR_MODULO=24): directed
// vector table plus hand-written square-wave, async-reset and alarm sequences.
module tb_time_counter;

    logic       clk;
    logic       rst_n;
    logic       sec_clk, run, load;
    logic [7:0] set_h, set_m, set_s;
    logic [7:0] o_h, o_m, o_s;
    logic       sec_p, day_p, err_p;
`ifdef TIME_COUNTER_ALARM_EN
    logic       alm_set, alm_on, alarm;
    logic [7:0] alm_h, alm_m;
`endif

    int checks = 0;
    int errors = 0;

    time_counter #(.TICKS_PER_SEC(1), .HOUR_MODULO(24)) dut (
        .i_CLK      (clk),
        .i_RST      (rst_n),
        .i_SEC_CLK  (sec_clk),
        .i_RUN      (run),
        .i_LOAD     (load),
        .i_SET_H    (set_h),
        .i_SET_M    (set_m),
        .i_SET_S    (set_s),
`ifdef TIME_COUNTER_ALARM_EN
        .i_ALM_SET  (alm_set),
        .i_ALM_H    (alm_h),
        .i_ALM_M    (alm_m),
        .i_ALM_ON   (alm_on),
        .o_ALARM    (alarm),
`endif
        .o_H        (o_h),
        .o_M        (o_m),
        .o_S        (o_s),
        .o_SEC_PULSE(sec_p),
        .o_DAY_PULSE(day_p),
        .o_LOAD_ERR (err_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sc;
        logic        run;
        logic        ld;
        logic [23:0] set;
        logic [23:0] exp_t;
        logic [2:0]  exp_p;   // {sec, day, err}
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic sc, input logic r, input logic ld,
                                input logic [23:0] st, input logic [23:0] et,
                                input logic [2:0] ep);
        vec_t v;
        v.sc = sc; v.run = r; v.ld = ld; v.set = st; v.exp_t = et; v.exp_p = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [23:0] et, input logic [2:0] ep);
        chk({name, " time"}, {8'h00, o_h, o_m, o_s}, {8'h00, et});
        chk({name, " pulses"}, {29'd0, sec_p, day_p, err_p}, {29'd0, ep});
    endtask

    // Advance one clock; outputs are read 1ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses;
        string nm;
        rst_n = 1'b0; sec_clk = 1'b1; run = 1'b1; load = 1'b0;
        set_h = 8'h00; set_m = 8'h00; set_s = 8'h00;
`ifdef TIME_COUNTER_ALARM_EN
        alm_set = 1'b0; alm_on = 1'b0; alm_h = 8'h00; alm_m = 8'h00;
`endif
        step(); step();
        chk_all("reset", 24'h000000, 3'b000);
        rst_n = 1'b1;

        // sc run ld set exp_time {sec,day,err}
        vq.push_back(mk(1, 1, 0, 24'h0,      24'h000000, 3'b000)); // released while high
        vq.push_back(mk(1, 1, 0, 24'h0,      24'h000000, 3'b000));
        vq.push_back(mk(0, 1, 0, 24'h0,      24'h000000, 3'b000));
        vq.push_back(mk(1, 1, 0, 24'h0,      24'h000001, 3'b100)); // first real rise
        vq.push_back(mk(1, 1, 0, 24'h0,      24'h000001, 3'b000));
        vq.push_back(mk(0, 1, 0, 24'h0,      24'h000001, 3'b000));
        vq.push_back(mk(0, 1, 1, 24'h235958, 24'h235958, 3'b000));
        vq.push_back(mk(1, 1, 0, 24'h0,      24'h235959, 3'b100));
        vq.push_back(mk(0, 1, 0, 24'h0,      24'h235959, 3'b000));
        vq.push_back(mk(1, 1, 0, 24'h0,      24'h000000, 3'b110)); // day wrap
        vq.push_back(mk(0, 1, 0, 24'h0,      24'h000000, 3'b000));
        vq.push_back(mk(0, 1, 1, 24'h126000, 24'h000000, 3'b001)); // bad minutes
        vq.push_back(mk(0, 1, 0, 24'h0,      24'h000000, 3'b000));
        vq.push_back(mk(0, 1, 1, 24'h240000, 24'h000000, 3'b001)); // bad hours
        vq.push_back(mk(1, 1, 1, 24'h123456, 24'h123456, 3'b000)); // load beats rise
        vq.push_back(mk(0, 1, 0, 24'h0,      24'h123456, 3'b000));
        vq.push_back(mk(1, 0, 0, 24'h0,      24'h123456, 3'b000)); // paused rises
        vq.push_back(mk(0, 0, 0, 24'h0,      24'h123456, 3'b000));
        vq.push_back(mk(1, 0, 0, 24'h0,      24'h123456, 3'b000));
        vq.push_back(mk(0, 0, 0, 24'h0,      24'h123456, 3'b000));
        vq.push_back(mk(1, 0, 0, 24'h0,      24'h123456, 3'b000));
        vq.push_back(mk(1, 1, 0, 24'h0,      24'h123456, 3'b000)); // resume high
        vq.push_back(mk(0, 1, 0, 24'h0,      24'h123456, 3'b000));
        vq.push_back(mk(1, 1, 0, 24'h0,      24'h123457, 3'b100));
        vq.push_back(mk(0, 1, 0, 24'h0,      24'h123457, 3'b000));
        vq.push_back(mk(1, 1, 1, 24'h1A0000, 24'h123458, 3'b101)); // reject keeps advance
        vq.push_back(mk(0, 1, 1, 24'h095959, 24'h095959, 3'b000));
        vq.push_back(mk(1, 1, 0, 24'h0,      24'h100000, 3'b100)); // hour units carry
        vq.push_back(mk(0, 1, 1, 24'h195959, 24'h195959, 3'b000));
        vq.push_back(mk(1, 1, 0, 24'h0,      24'h200000, 3'b100));
        vq.push_back(mk(0, 1, 1, 24'h000959, 24'h000959, 3'b000));
        vq.push_back(mk(1, 1, 0, 24'h0,      24'h001000, 3'b100)); // minute tens carry
        vq.push_back(mk(0, 1, 1, 24'h0005A0, 24'h001000, 3'b001)); // bad seconds nibble

        foreach (vq[i]) begin
            sec_clk = vq[i].sc; run = vq[i].run; load = vq[i].ld;
            {set_h, set_m, set_s} = vq[i].set;
            step();
            nm = $sformatf("vec%0d", i);
            chk_all(nm, vq[i].exp_t, vq[i].exp_p);
        end
        load = 1'b0; sec_clk = 1'b0; run = 1'b1;

        // 10-cycle square wave: exactly one single-cycle pulse per period
        load = 1'b1; {set_h, set_m, set_s} = 24'h000000;
        step();
        load = 1'b0;
        for (int p = 1; p <= 5; p++) begin
            pulses = 0;
            for (int c = 0; c < 10; c++) begin
                sec_clk = (c < 5);
                step();
                if (sec_p) pulses++;
            end
            chk($sformatf("sqw%0d pulses", p), 32'(pulses), 32'd1);
            chk($sformatf("sqw%0d sec", p), {24'd0, o_s}, 32'(p));
        end

        // Asynchronous reset between clock edges
        load = 1'b1; {set_h, set_m, set_s} = 24'h112233;
        step();
        load = 1'b0;
        chk_all("preload", 24'h112233, 3'b000);
        #2 rst_n = 1'b0;
        #1;
        chk_all("async rst", 24'h000000, 3'b000);
        step();
        rst_n = 1'b1;

`ifdef TIME_COUNTER_ALARM_EN
        // Alarm at 00:01 fires on the advance into 00:01:00
        sec_clk = 1'b0; alm_on = 1'b1;
        alm_set = 1'b1; alm_h = 8'h00; alm_m = 8'h01;
        load = 1'b1; {set_h, set_m, set_s} = 24'h000059;
        step();
        alm_set = 1'b0; load = 1'b0;
        chk("alm idle", {31'd0, alarm}, 32'd0);
        sec_clk = 1'b1;
        step();
        chk_all("alm hit", 24'h000100, 3'b100);
        chk("alm pulse", {31'd0, alarm}, 32'd1);
        sec_clk = 1'b0;
        step();
        chk("alm width", {31'd0, alarm}, 32'd0);
        // Invalid alarm rejected; load landing on alarm time is silent
        alm_set = 1'b1; alm_h = 8'h25; alm_m = 8'h00;
        load = 1'b1; {set_h, set_m, set_s} = 24'h000100;
        step();
        alm_set = 1'b0; load = 1'b0;
        chk("alm bad err", {31'd0, err_p}, 32'd1);
        chk("alm on load", {31'd0, alarm}, 32'd0);
        load = 1'b1; {set_h, set_m, set_s} = 24'h000059;
        step();
        load = 1'b0; sec_clk = 1'b1;
        step();
        chk("alm kept", {31'd0, alarm}, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
